// File: rtl/risc16_ctrl_fsm_pkg.sv
// rtl/risc16_ctrl_fsm_pkg.sv - opcode, state, ALU function and select encodings for the RiSC16 control FSM
package risc16_ctrl_fsm_pkg;

    localparam int FUNCT_LEN = 1;
    localparam logic [FUNCT_LEN-1:0] FUNCT_ADD  = 1'b0;
    localparam logic [FUNCT_LEN-1:0] FUNCT_NAND = 1'b1;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    localparam int STATE_LEN = 3;
    typedef enum logic [STATE_LEN-1:0] {
        S_RST    = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    localparam logic [1:0] PCSRC_INC = 2'd0;
    localparam logic [1:0] PCSRC_BR  = 2'd1;
    localparam logic [1:0] PCSRC_REG = 2'd2;

    localparam logic [1:0] WSRC_ALU = 2'd0;
    localparam logic [1:0] WSRC_MEM = 2'd1;
    localparam logic [1:0] WSRC_PC1 = 2'd2;
    localparam logic [1:0] WSRC_LUI = 2'd3;

endpackage

// File: rtl/risc16_retire_cnt.sv
// rtl/risc16_retire_cnt.sv - 32-bit wrapping retired-instruction counter, built only with RISC16_PERF_EN
`ifdef RISC16_PERF_EN
module risc16_retire_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] count
);

    logic [31:0] count_q;
    logic [31:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`endif

// File: rtl/risc16_ctrl_fsm.sv
// rtl/risc16_ctrl_fsm.sv - multi-cycle fetch/decode/exec/mem/wb control FSM for the RiSC16 core (RISC16_PERF_EN adds instr_cnt)
module risc16_ctrl_fsm
    import risc16_ctrl_fsm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2:0]           opcode,
    input  logic [6:0]           imm7,
    input  logic                 eq,
    input  logic                 mem_ack,
    output logic                 ir_we,
    output logic                 pc_we,
    output logic [1:0]           pc_src,
    output logic                 rf_we,
    output logic [1:0]           rf_wsrc,
    output logic [FUNCT_LEN-1:0] alu_funct,
    output logic                 alu_srcb,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 mem_asel,
    output logic                 halted
`ifdef RISC16_PERF_EN
    ,
    output logic [31:0]          instr_cnt
`endif
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = PCSRC_INC;
        rf_we     = 1'b0;
        rf_wsrc   = WSRC_ALU;
        alu_funct = FUNCT_ADD;
        alu_srcb  = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_asel  = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ack;
                if (mem_ack) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (opcode == OP_JALR && imm7 != 7'd0) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_d = S_WB;
                case (opcode)
                    OP_NAND: alu_funct = FUNCT_NAND;
                    OP_ADDI: alu_srcb = 1'b1;
                    OP_LW, OP_SW: begin
                        alu_srcb = 1'b1;
                        state_d  = S_MEM;
                    end
                    OP_BEQ: begin
                        pc_we   = 1'b1;
                        pc_src  = eq ? PCSRC_BR : PCSRC_INC;
                        state_d = S_FETCH;
                    end
                    OP_JALR: begin
                        rf_we   = 1'b1;
                        rf_wsrc = WSRC_PC1;
                        pc_we   = 1'b1;
                        pc_src  = PCSRC_REG;
                        state_d = S_FETCH;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                // ALU keeps computing base+simm7 so the data address stays stable until ack
                mem_req  = 1'b1;
                mem_asel = 1'b1;
                mem_we   = (opcode == OP_SW);
                alu_srcb = 1'b1;
                if (mem_ack) begin
                    if (opcode == OP_SW) begin
                        pc_we   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we   = 1'b1;
                pc_we   = 1'b1;
                state_d = S_FETCH;
                case (opcode)
                    OP_LW: begin
                        rf_wsrc  = WSRC_MEM;
                        alu_srcb = 1'b1;
                    end
                    OP_LUI:  rf_wsrc = WSRC_LUI;
                    OP_NAND: alu_funct = FUNCT_NAND;
                    OP_ADDI: alu_srcb = 1'b1;
                    default: ;
                endcase
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_RST;
        endcase
    end

`ifdef RISC16_PERF_EN
    risc16_retire_cnt u_retire_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_we),
        .count (instr_cnt)
    );
`endif

endmodule

// File: tb/tb_risc16_ctrl_fsm.sv
// tb/tb_risc16_ctrl_fsm.sv - scoreboard bench for risc16_ctrl_fsm with randomized instruction stream and ack delays
module tb_risc16_ctrl_fsm;
    import risc16_ctrl_fsm_pkg::*;

    localparam int OW = 12 + FUNCT_LEN;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [2:0]           opcode = 3'd0;
    logic [6:0]           imm7 = 7'd0;
    logic                 eq = 1'b0;
    logic                 mem_ack = 1'b0;
    logic                 ir_we, pc_we, rf_we, alu_srcb, mem_req, mem_we, mem_asel, halted;
    logic [1:0]           pc_src, rf_wsrc;
    logic [FUNCT_LEN-1:0] alu_funct;
`ifdef RISC16_PERF_EN
    logic [31:0]          instr_cnt;
`endif

    risc16_ctrl_fsm dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .imm7      (imm7),
        .eq        (eq),
        .mem_ack   (mem_ack),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .rf_we     (rf_we),
        .rf_wsrc   (rf_wsrc),
        .alu_funct (alu_funct),
        .alu_srcb  (alu_srcb),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_asel  (mem_asel),
        .halted    (halted)
`ifdef RISC16_PERF_EN
        ,
        .instr_cnt (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit                   halt;
        int                   lat;
        int                   n_rf;
        logic [1:0]           wsrc;
        logic [1:0]           psrc;
        int                   n_dacc;
        logic                 dwe;
        logic [FUNCT_LEN-1:0] funct;
        logic                 srcb;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    function automatic logic [OW-1:0] outs();
        return {ir_we, pc_we, pc_src, rf_we, rf_wsrc, alu_funct, alu_srcb,
                mem_req, mem_we, mem_asel, halted};
    endfunction

    // ---------------- monitor ----------------
    bit                   active = 0;
    bit                   prev_hold = 0;
    logic                 prev_asel = 0, prev_we = 0;
    int                   since_rst = 0;
    int                   cyc = 0, n_ir = 0, n_rf = 0, n_dacc = 0;
    logic [1:0]           o_wsrc;
    logic [FUNCT_LEN-1:0] o_funct;
    logic                 o_srcb, o_dwe;
    int unsigned          perf_model = 0;
    exp_t                 me;

    always @(negedge clk) begin
        #3;
        if (!rst_n) begin
            chk("reset_outs", 32'(outs()), 32'd0);
            active     = 0;
            since_rst  = 0;
            prev_hold  = 0;
            perf_model = 0;
        end else begin
            since_rst++;
            if (since_rst == 1) chk("srst_outs", 32'(outs()), 32'd0);
            if (since_rst == 2) chk("first_fetch", {mem_req, mem_asel, mem_we}, 3'b100);
            if (prev_hold) chk("mem_stable", {mem_req, mem_asel, mem_we}, {1'b1, prev_asel, prev_we});
            if (ir_we) chk("ir_we_ctx", {mem_req, mem_asel, mem_ack}, 3'b101);
            if (!active && mem_req && !mem_asel && !halted) begin
                active = 1; cyc = 0; n_ir = 0; n_rf = 0; n_dacc = 0;
            end
            if (active) cyc++;
            if (halted) begin
                chk("halt_outs", 32'(outs()), 32'd1);
                if (active) begin
                    active = 0;
                    if (sb.size() == 0) fail_now("halt_unexpected");
                    else begin
                        me = sb.pop_front();
                        chk("halt_flag", 32'(me.halt), 32'd1);
                        chk("halt_lat", cyc, me.lat);
                    end
                end
            end else if (active) begin
                if (ir_we) n_ir++;
                if (rf_we) begin
                    n_rf++; o_wsrc = rf_wsrc; o_funct = alu_funct; o_srcb = alu_srcb;
                end
                if (mem_req && mem_asel && mem_ack) begin
                    n_dacc++; o_dwe = mem_we;
                end
                if (pc_we) begin
                    active = 0;
                    if (sb.size() == 0) fail_now("unexpected_retire");
                    else begin
                        me = sb.pop_front();
                        chk("retire_not_halt", 32'(me.halt), 32'd0);
                        chk("latency", cyc, me.lat);
                        chk("ir_we_count", n_ir, 1);
                        chk("rf_we_count", n_rf, me.n_rf);
                        chk("pc_src", pc_src, me.psrc);
                        if (me.n_rf > 0) begin
                            chk("rf_wsrc", o_wsrc, me.wsrc);
                            chk("alu_funct", 32'(o_funct), 32'(me.funct));
                            chk("alu_srcb", o_srcb, me.srcb);
                        end
                        chk("data_access", n_dacc, me.n_dacc);
                        if (me.n_dacc > 0) chk("mem_we", o_dwe, me.dwe);
                    end
                end
            end else if (pc_we || rf_we) begin
                fail_now("write_outside_instr");
            end
            prev_hold = mem_req && !mem_ack;
            prev_asel = mem_asel;
            prev_we   = mem_we;
`ifdef RISC16_PERF_EN
            chk("instr_cnt", instr_cnt, perf_model);
            if (pc_we) perf_model++;
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_req();
        int n = 0;
        while (!mem_req && n < 50) begin
            mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (!mem_req) fail_now("req_timeout");
    endtask

    task automatic serve(input int d, input bit set_ir, input logic [2:0] op,
                         input logic [6:0] im, input logic ev);
        wait_req();
        mem_ack = 1'b0;
        repeat (d) @(negedge clk);
        mem_ack = 1'b1;
        if (set_ir) begin
            opcode = op; imm7 = im; eq = ev;
        end
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        mem_ack = 1'b1;
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        mem_ack = 1'b0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [6:0] im, input logic ev,
                         input int fd, input int md, input bit abort);
        exp_t e;
        int   n;
        bit   is_mem;
        is_mem   = (op == OP_LW || op == OP_SW);
        e.halt   = (op == OP_JALR && im != 7'd0);
        e.lat    = ((op == OP_BEQ || op == OP_JALR) ? 3 : (op == OP_LW ? 5 : 4))
                   + fd + (is_mem ? md : 0);
        if (e.halt) e.lat = 3 + fd;
        e.n_rf   = (op == OP_BEQ || op == OP_SW) ? 0 : 1;
        e.wsrc   = (op == OP_LW) ? 2'd1 : (op == OP_LUI) ? 2'd3 : (op == OP_JALR) ? 2'd2 : 2'd0;
        e.psrc   = (op == OP_BEQ) ? (ev ? 2'd1 : 2'd0) : (op == OP_JALR) ? 2'd2 : 2'd0;
        e.n_dacc = is_mem ? 1 : 0;
        e.dwe    = (op == OP_SW);
        e.funct  = (op == OP_NAND) ? FUNCT_NAND : FUNCT_ADD;
        e.srcb   = (op == OP_ADDI || op == OP_LW);
        if (!abort) sb.push_back(e);
        serve(fd, 1'b1, op, im, ev);
        if (e.halt) return;
        if (is_mem) begin
            if (abort) begin
                wait_req();
                mem_ack = 1'b0;
                do_reset();
                return;
            end
            serve(md, 1'b0, 3'd0, 7'd0, 1'b0);
        end
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("retire_timeout");
            sb.delete();
        end
    endtask

    initial begin
        logic [2:0] op;
        rst_n = 1'b0;
        do_reset();
        issue(OP_ADD,  7'h00, 1'b0, 0, 0, 1'b0);
        issue(OP_LW,   7'h12, 1'b0, 2, 1, 1'b0);
        issue(OP_BEQ,  7'h05, 1'b1, 0, 0, 1'b0);
        issue(OP_BEQ,  7'h05, 1'b0, 1, 0, 1'b0);
        issue(OP_JALR, 7'h00, 1'b1, 0, 0, 1'b0);
        issue(OP_NAND, 7'h3f, 1'b0, 0, 0, 1'b0);
        issue(OP_LUI,  7'h7f, 1'b0, 0, 0, 1'b0);
        issue(OP_ADDI, 7'h01, 1'b0, 1, 0, 1'b0);
        issue(OP_SW,   7'h02, 1'b0, 0, 2, 1'b0);
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            issue(op, (op == OP_JALR) ? 7'd0 : 7'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        end
        issue(OP_LW,   7'h00, 1'b0, 0, 2, 1'b1);
        issue(OP_SW,   7'h00, 1'b0, 1, 1, 1'b0);
        issue(OP_ADD,  7'h00, 1'b0, 0, 0, 1'b0);
        issue(OP_JALR, 7'h01, 1'b0, 1, 0, 1'b0);
        repeat (25) begin
            mem_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        do_reset();
        issue(OP_ADDI, 7'h10, 1'b0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
